// File: rtl/mv_pkg.sv
// mv_pkg: shared definitions for the pearray_my host driver.
//   - mv_state_e   : host controller FSM states
//   - mv_n/mv_nn   : vector length N and matrix size N*N for a given H_SIZE
//   - mv_word_addr : operand index k -> BRAM word index in the array's layout
//                    (vector in words 0..N-1, matrix row r at word (r+1)*N)
package mv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_READ,
    ST_OUT
  } mv_state_e;

  function automatic int unsigned mv_n(input int unsigned h);
    return 32'd1 << h;
  endfunction

  function automatic int unsigned mv_nn(input int unsigned h);
    return 32'd1 << (2 * h);
  endfunction

  // Operand words arrive as N vector words followed by the matrix in
  // row-major order; matrix row r lives one N-word block above row r-1.
  function automatic logic [31:0] mv_word_addr(input logic [31:0] k,
                                               input int unsigned h);
    logic [31:0] n;
    logic [31:0] r;
    logic [31:0] c;
    n = 32'd1 << h;
    if (k < n) return k;
    r = (k - n) >> h;
    c = (k - n) & (n - 32'd1);
    return ((r + 32'd1) << h) | c;
  endfunction

endpackage

// File: rtl/mv_host_ctrl.sv
// mv_host_ctrl: host-side driver for the pearray_my int8 matrix-vector engine.
// Loads N vector words and N*N matrix words from the s_* stream into the
// shared BRAM, pulses start, waits for done (optionally bounded by TIMEOUT),
// then reads the N result words back and emits them on the m_* stream.
//
// Ports:
//   aclk, aresetn             clock, synchronous active-low reset
//   s_valid/s_ready/s_data    operand input stream
//   m_valid/m_ready/m_data    result output stream, m_last on result N-1
//   start, done               handshake with the array
//   busy, timeout_err         status (timeout_err is sticky until next load)
//   BRAM_ADDR/WRDATA/WE/RDDATA host port of the shared BRAM (byte address)
module mv_host_ctrl
  import mv_pkg::*;
#(
  parameter int unsigned H_SIZE  = 6,
  parameter int unsigned TIMEOUT = 2**20
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        start,
  input  logic        done,
  output logic        busy,
  output logic        timeout_err,
  output logic [31:0] BRAM_ADDR,
  output logic [31:0] BRAM_WRDATA,
  output logic [3:0]  BRAM_WE,
  input  logic [31:0] BRAM_RDDATA
);

  localparam int unsigned N   = mv_n(H_SIZE);
  localparam int unsigned NN  = mv_nn(H_SIZE);
  localparam int unsigned KW  = 2 * H_SIZE + 1;
  localparam int unsigned WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // k reaches N+N*N one cycle after the final handshake: the drain cycle in
  // which the last write is on the BRAM port and s_ready is already low.
  localparam logic [KW-1:0]     K_DRAIN = KW'(N + NN);
  localparam logic [H_SIZE-1:0] J_LAST  = H_SIZE'(N - 1);
  localparam logic [WCW-1:0]    W_LAST  = WCW'(TIMEOUT - 1);

  mv_state_e         state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [H_SIZE-1:0] j_q, j_d;
  logic [WCW-1:0]    wait_q, wait_d;
  logic              rd_ph_q, rd_ph_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wrdata_q, wrdata_d;
  logic [3:0]        we_q, we_d;
  logic [31:0]       mdata_q, mdata_d;
  logic              terr_q, terr_d;
  logic              hs;

  // Gated by aresetn so s_ready reads 0 while reset is held.
  assign s_ready = aresetn &&
                   ((state_q == ST_IDLE) ||
                    ((state_q == ST_LOAD) && (k_q != K_DRAIN)));
  assign hs      = s_valid && s_ready;

  always_comb begin
    // NOTE: every variable gets its default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    k_d      = k_q;
    j_d      = j_q;
    wait_d   = wait_q;
    rd_ph_d  = rd_ph_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    we_d     = 4'h0;
    mdata_d  = mdata_q;
    terr_d   = terr_q;

    // k_q is 0 whenever the FSM is idle, so IDLE and LOAD share this path.
    if (hs) begin
      addr_d   = mv_word_addr(32'(k_q), H_SIZE) << 2;
      wrdata_d = s_data;
      we_d     = 4'hF;
      k_d      = k_q + KW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (hs) begin
          terr_d  = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (k_q == K_DRAIN) begin
          // Hand the BRAM to the array with a quiet port.
          k_d      = '0;
          addr_d   = '0;
          wrdata_d = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done) begin
          j_d     = '0;
          rd_ph_d = 1'b0;
          addr_d  = '0;
          state_d = ST_READ;
        end else if ((TIMEOUT != 0) && (wait_q == W_LAST)) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      ST_READ: begin
        // Address is on the port in phase 0; data is valid at the end of
        // phase 1 because the array clocks the BRAM on the opposite edge.
        if (!rd_ph_q) begin
          rd_ph_d = 1'b1;
        end else begin
          rd_ph_d = 1'b0;
          mdata_d = BRAM_RDDATA;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          if (j_q == J_LAST) begin
            state_d = ST_IDLE;
          end else begin
            j_d     = j_q + H_SIZE'(1);
            addr_d  = 32'(j_d) << 2;
            state_d = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update from
  // the same pre-edge values; reset is sampled on the clock edge.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      j_q      <= '0;
      wait_q   <= '0;
      rd_ph_q  <= 1'b0;
      addr_q   <= '0;
      wrdata_q <= '0;
      we_q     <= 4'h0;
      mdata_q  <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      j_q      <= j_d;
      wait_q   <= wait_d;
      rd_ph_q  <= rd_ph_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      we_q     <= we_d;
      mdata_q  <= mdata_d;
      terr_q   <= terr_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign start       = (state_q == ST_START);
  assign m_valid     = (state_q == ST_OUT);
  assign m_last      = (state_q == ST_OUT) && (j_q == J_LAST);
  assign m_data      = mdata_q;
  assign timeout_err = terr_q;
  assign BRAM_ADDR   = addr_q;
  assign BRAM_WRDATA = wrdata_q;
  assign BRAM_WE     = we_q;

endmodule

// File: tb/tb_mv_host_ctrl.sv
// tb_mv_host_ctrl: directed bench for mv_host_ctrl with H_SIZE=2 (N=4,
// 20 operand words) and TIMEOUT=64. Contains a BRAM model with the array's
// two-cycle read path, a model array that writes results and pulses done,
// and a monitor that checks writes, start timing and result stream.
module tb_mv_host_ctrl;

  localparam int H  = 2;
  localparam int N  = 4;
  localparam int TO = 64;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        start;
  logic        done;
  logic        busy;
  logic        timeout_err;
  logic [31:0] BRAM_ADDR;
  logic [31:0] BRAM_WRDATA;
  logic [3:0]  BRAM_WE;
  logic [31:0] BRAM_RDDATA;

  always #5 aclk = ~aclk;

  mv_host_ctrl #(.H_SIZE(H), .TIMEOUT(TO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .start(start), .done(done), .busy(busy), .timeout_err(timeout_err),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_WRDATA(BRAM_WRDATA), .BRAM_WE(BRAM_WE),
    .BRAM_RDDATA(BRAM_RDDATA)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // BRAM model: write on WE, read registered once (data valid the cycle
  // after the address), plus a port for the model array to drop results.
  logic [31:0] mem [0:31];
  logic [31:0] rd_q = '0;
  logic [31:0] arr_vals [0:3];
  logic        arr_load;

  always @(posedge aclk) begin
    if (BRAM_WE == 4'hF) mem[BRAM_ADDR[6:2]] <= BRAM_WRDATA;
    if (arr_load) for (int i = 0; i < N; i++) mem[i] <= arr_vals[i];
    rd_q <= mem[BRAM_ADDR[6:2]];
  end
  assign BRAM_RDDATA = rd_q;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Monitor and its expectation model.
  typedef struct {
    int          cyc;
    int unsigned addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] rq[$];
  wr_t         mon_e;
  int unsigned mon_w;
  int          model_k = 0;
  int          mon_ridx = 0;
  int          exp_start_cyc = -1;
  int          start_cnt = 0;
  bit          mon_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data, prev_addr;
  logic        prev_last;
  logic [31:0] exp_r;

  always @(negedge aclk) begin
    if (mon_en) begin
      if (BRAM_WE != 4'h0) begin
        if (wq.size() == 0) begin
          check("unexpected_write_addr", BRAM_ADDR, 32'hFFFF_FFFF);
        end else begin
          mon_e = wq.pop_front();
          check("wr_cycle", cyc, mon_e.cyc);
          check("wr_addr", BRAM_ADDR, mon_e.addr * 4);
          check("wr_data", BRAM_WRDATA, mon_e.data);
          check("wr_we", {28'd0, BRAM_WE}, 32'hF);
        end
      end
      if (start) begin
        start_cnt++;
        check("start_cycle", cyc, exp_start_cyc);
      end
      if (s_valid && s_ready) begin
        mon_w = (model_k < N) ? model_k
              : N * ((model_k - N) / N + 1) + (model_k - N) % N;
        wq.push_back('{cyc + 1, mon_w, s_data});
        if (model_k == N + N * N - 1) begin
          exp_start_cyc = cyc + 2;
          model_k = 0;
        end else begin
          model_k++;
        end
      end
      if (rq.size() == 0) check("m_valid_without_result", {31'd0, m_valid}, 0);
      if (prev_stall) begin
        check("hold_valid", {31'd0, m_valid}, 1);
        check("hold_data", m_data, prev_data);
        check("hold_last", {31'd0, m_last}, {31'd0, prev_last});
        check("hold_no_read", BRAM_ADDR, prev_addr);
      end
      if (m_valid && m_ready && rq.size() != 0) begin
        exp_r = rq.pop_front();
        check("res_data", m_data, exp_r);
        check("res_last", {31'd0, m_last}, {31'd0, mon_ridx == N - 1});
        mon_ridx = (mon_ridx == N - 1) ? 0 : mon_ridx + 1;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      prev_addr  = BRAM_ADDR;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_s_ready"}, {31'd0, s_ready}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_start"}, {31'd0, start}, 0);
    check({tag, "_m_valid"}, {31'd0, m_valid}, 0);
    check({tag, "_m_last"}, {31'd0, m_last}, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_timeout_err"}, {31'd0, timeout_err}, 0);
    check({tag, "_addr"}, BRAM_ADDR, 0);
    check({tag, "_wrdata"}, BRAM_WRDATA, 0);
    check({tag, "_we"}, {28'd0, BRAM_WE}, 0);
  endtask

  task automatic send_word(input logic [31:0] d);
    int  guard = 0;
    bit  acc;
    s_valid = 1'b1;
    s_data  = d;
    do begin
      @(negedge aclk);
      acc = s_ready;
      @(posedge aclk);
      #1;
      guard++;
    end while (!acc && guard < 50);
    if (!acc) check("s_ready_wait", {31'd0, acc}, 1);
    s_valid = 1'b0;
  endtask

  task automatic wait_start(output bit seen);
    int guard = 0;
    seen = 1'b0;
    while (!seen && guard < 40) begin
      @(negedge aclk);
      seen = start;
      guard++;
    end
    check("start_seen", {31'd0, seen}, 1);
  endtask

  // Model array: done arrives dly cycles after the start cycle.
  task automatic respond(input int dly, input logic [31:0] base);
    repeat (dly) @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++) begin
      arr_vals[i] = base + 32'(i);
      rq.push_back(base + 32'(i));
    end
    arr_load = 1'b1;
    done     = 1'b1;
    @(posedge aclk);
    #1;
    arr_load = 1'b0;
    done     = 1'b0;
  endtask

  logic [31:0] exp_lit [0:3];

  task automatic recv_results(input int stall_idx);
    for (int i = 0; i < N; i++) begin
      int g = 0;
      do begin
        @(negedge aclk);
        g++;
      end while (!m_valid && g < 40);
      check("m_valid_seen", {31'd0, m_valid}, 1);
      if (i == stall_idx) begin
        for (int w = 0; w < 10; w++) begin
          @(posedge aclk);
          #1;
          done = (w == 4);
          @(negedge aclk);
        end
        done = 1'b0;
        check("stall_valid", {31'd0, m_valid}, 1);
        check("stall_data", m_data, exp_lit[i]);
      end
      @(posedge aclk);
      #1;
      m_ready = 1'b1;
      @(negedge aclk);
      check("lit_data", m_data, exp_lit[i]);
      check("lit_last", {31'd0, m_last}, {31'd0, i == N - 1});
      @(posedge aclk);
      #1;
      m_ready = 1'b0;
    end
    @(negedge aclk);
    check("busy_after", {31'd0, busy}, 0);
    check("m_valid_after", {31'd0, m_valid}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    bit seen;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    aresetn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    done = 1'b0; arr_load = 1'b0;
    for (int i = 0; i < N; i++) arr_vals[i] = '0;

    // Reset state.
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check_zero("rst");
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    mon_en  = 1'b1;
    @(negedge aclk);
    check("idle_s_ready", {31'd0, s_ready}, 1);
    check("idle_busy", {31'd0, busy}, 0);

    // Load 1: words 1..20 back to back, a stray done mid-load.
    @(posedge aclk);
    #1;
    for (int k = 0; k < 20; k++) begin
      done = (k == 10);
      send_word(32'(k + 1));
    end
    done = 1'b0;
    wait_start(seen);
    check("mem_row3_c3", mem[19], 32'd20);
    check("mem_vec0", mem[0], 32'd1);
    exp_lit = '{32'h0000000A, 32'h0000000B, 32'h0000000C, 32'h0000000D};
    respond(50, 32'h0000000A);
    recv_results(1);
    check("start_count_1", start_cnt, 1);

    // Load 2: reset after 7 words.
    for (int k = 0; k < 7; k++) send_word(32'h100 + 32'(k));
    mon_en  = 1'b0;
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check_zero("midrst");
    @(posedge aclk);
    #1;
    wq.delete();
    model_k    = 0;
    prev_stall = 1'b0;
    aresetn    = 1'b1;
    mon_en     = 1'b1;

    // Load 3: fresh 20-word load with gaps, done never comes.
    for (int k = 0; k < 20; k++) begin
      if (k % 5 == 4) begin
        @(posedge aclk);
        #1;
      end
      send_word(32'h200 + 32'(k));
    end
    wait_start(seen);
    check("mem_fresh_vec0", mem[0], 32'h200);
    repeat (TO) @(negedge aclk);
    check("to_last_wait_err", {31'd0, timeout_err}, 0);
    check("to_last_wait_busy", {31'd0, busy}, 1);
    @(negedge aclk);
    check("to_err_set", {31'd0, timeout_err}, 1);
    check("to_idle", {31'd0, busy}, 0);
    check("to_no_valid", {31'd0, m_valid}, 0);
    repeat (5) @(negedge aclk);
    check("to_err_sticky", {31'd0, timeout_err}, 1);
    check("to_start_count", start_cnt, 2);

    // Load 4: first word clears the flag; done lands on the timeout cycle.
    @(posedge aclk);
    #1;
    send_word(32'h300);
    @(negedge aclk);
    check("to_err_cleared", {31'd0, timeout_err}, 0);
    @(posedge aclk);
    #1;
    for (int k = 1; k < 20; k++) send_word(32'h300 + 32'(k));
    wait_start(seen);
    exp_lit = '{32'h00000011, 32'h00000012, 32'h00000013, 32'h00000014};
    respond(TO, 32'h00000011);
    recv_results(-1);
    check("race_no_err", {31'd0, timeout_err}, 0);
    check("start_count_total", start_cnt, 3);
    check("writes_drained", wq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
